// File: rtl/ctl_pkg.sv
// Shared definitions for the fetch handshake pipeline.
//   DEPTH_MIN/DEPTH_MAX : legal range of the pipeline depth parameter
//   celem_next()        : next state of one registered C-element stage
package ctl_pkg;

  localparam int unsigned DEPTH_MIN = 1;
  localparam int unsigned DEPTH_MAX = 16;

  // The stage rises when its predecessor is full and its successor is empty.
  // It falls when its predecessor is empty and its successor is full.
  // Otherwise it holds.
  function automatic logic celem_next(input logic c_prev,
                                      input logic c_self,
                                      input logic c_next);
    return (c_prev & ~c_next) | (c_self & (c_prev | ~c_next));
  endfunction

endpackage

// File: rtl/ctl_celem.sv
// One handshake stage: a registered C-element bit plus its data register.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   c_prev   : predecessor state (upstream request for stage 0)
//   c_next   : successor state (downstream ack for the last stage)
//   d_in     : predecessor data, captured when this stage fills
//   c        : this stage's C-element state
//   d        : this stage's data register
module ctl_celem
  import ctl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             c_prev,
  input  logic             c_next,
  input  logic [WIDTH-1:0] d_in,
  output logic             c,
  output logic [WIDTH-1:0] d
);

  logic c_nxt;
  logic fill;

  always_comb begin
    c_nxt = celem_next(c_prev, c, c_next);
    fill  = c_nxt & ~c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c <= 1'b0;
      d <= '0;
    end else begin
      c <= c_nxt;
      if (fill) d <= d_in;
    end
  end

endmodule

// File: rtl/ctl_fetch_pipe.sv
// Fetch pipeline built from a chain of DEPTH registered C-element stages.
// The pipeline uses a 4-phase handshake on both sides.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   req_i    : upstream request
//   data_i   : upstream data, valid while req_i=1
//   ack_i    : acknowledge to upstream (stage 0 state)
//   req_o    : request to downstream (last stage state)
//   data_o   : data to downstream (last stage data register)
//   ack_o    : acknowledge from downstream
//   stage_o  : all stage states c[DEPTH-1:0]
//   err_o    : sticky upstream protocol-violation flag
module ctl_fetch_pipe
  import ctl_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ack_i,
  output logic             req_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             ack_o,
  output logic [DEPTH-1:0] stage_o,
  output logic             err_o
);

  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_depth_check
    $error("ctl_fetch_pipe: DEPTH out of range");
  end

  logic [DEPTH-1:0] c;
  // The vector is {ack_o, c, req_i}. Stage k therefore sees its neighbours
  // at ext[k] and ext[k+2]. This avoids special-casing the end stages.
  logic [DEPTH+1:0] ext;
  logic [WIDTH-1:0] dchain [DEPTH+1];
  logic             req_q;
  logic             err;

  assign ext       = {ack_o, c, req_i};
  assign dchain[0] = data_i;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    ctl_celem #(.WIDTH(WIDTH)) u_stage (
      .clk    (clk),
      .rst    (rst),
      .c_prev (ext[k]),
      .c_next (ext[k+2]),
      .d_in   (dchain[k]),
      .c      (c[k]),
      .d      (dchain[k+1])
    );
  end

  // Upstream may only toggle req_i after ack_i has followed the previous phase.
  // A req_i fall while ack_i=0 is a violation.
  // A req_i rise while ack_i=1 is a violation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q <= 1'b0;
      err   <= 1'b0;
    end else begin
      req_q <= req_i;
      if ((req_q & ~req_i & ~c[0]) | (~req_q & req_i & c[0])) err <= 1'b1;
    end
  end

  assign ack_i   = c[0];
  assign req_o   = c[DEPTH-1];
  assign data_o  = dchain[DEPTH];
  assign stage_o = c;
  assign err_o   = err;

endmodule

// File: tb/tb_ctl_fetch_pipe.sv
module tb_ctl_fetch_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_i;
  logic [7:0] data_i;
  logic       ack_i;
  logic       req_o;
  logic [7:0] data_o;
  logic       ack_o;
  logic [2:0] stage_o;
  logic       err_o;

  logic       req1_i;
  logic [7:0] data1_i;
  logic       ack1_i;
  logic       req1_o;
  logic [7:0] data1_o;
  logic       ack1_o;
  logic [0:0] stage1_o;
  logic       err1_o;

  always #5 clk = ~clk;

  ctl_fetch_pipe #(.DEPTH(3), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .data_i(data_i), .ack_i(ack_i),
    .req_o(req_o), .data_o(data_o), .ack_o(ack_o), .stage_o(stage_o), .err_o(err_o)
  );

  ctl_fetch_pipe #(.DEPTH(1), .WIDTH(8)) dut1 (
    .clk(clk), .rst(rst), .req_i(req1_i), .data_i(data1_i), .ack_i(ack1_i),
    .req_o(req1_o), .data_o(data1_o), .ack_o(ack1_o), .stage_o(stage1_o), .err_o(err1_o)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] sb [$];
  logic       prev_ack;
  logic       prev_req;

  typedef struct {
    logic       req;
    logic [7:0] d;
    logic       ack;
    logic [2:0] e_stage;
    logic [7:0] e_data;
  } vec_t;

  vec_t vt [13];

  typedef struct {
    logic req;
    logic ack;
    logic e_c;
  } vec1_t;

  vec1_t v1 [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock. Outputs are sampled 1 time unit after the edge.
  // Inputs are still the values the edge sampled.
  task automatic step();
    @(posedge clk);
    #1;
    if (ack_i && !prev_ack) sb.push_back(data_i);
    if (req_o && !prev_req) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: got token %0h expected none", data_o);
      end else begin
        check("sb_data", {24'h0, data_o}, {24'h0, sb.pop_front()});
      end
    end
    prev_ack = ack_i;
    prev_req = req_o;
  endtask

  task automatic do_reset();
    req_i   = 1'b0;
    data_i  = 8'h00;
    ack_o   = 1'b0;
    req1_i  = 1'b0;
    data1_i = 8'h00;
    ack1_o  = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    prev_ack = 1'b0;
    prev_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{1'b1, 8'hA5, 1'b0, 3'b001, 8'h00};
    vt[1]  = '{1'b1, 8'hA5, 1'b0, 3'b011, 8'h00};
    vt[2]  = '{1'b1, 8'hA5, 1'b0, 3'b111, 8'hA5};
    vt[3]  = '{1'b0, 8'h00, 1'b0, 3'b110, 8'hA5};
    vt[4]  = '{1'b0, 8'h00, 1'b0, 3'b100, 8'hA5};
    vt[5]  = '{1'b1, 8'h3C, 1'b0, 3'b101, 8'hA5};
    vt[6]  = '{1'b1, 8'h3C, 1'b1, 3'b001, 8'hA5};
    vt[7]  = '{1'b1, 8'h3C, 1'b0, 3'b011, 8'hA5};
    vt[8]  = '{1'b1, 8'h3C, 1'b0, 3'b111, 8'h3C};
    vt[9]  = '{1'b0, 8'h00, 1'b1, 3'b110, 8'h3C};
    vt[10] = '{1'b0, 8'h00, 1'b1, 3'b100, 8'h3C};
    vt[11] = '{1'b0, 8'h00, 1'b1, 3'b000, 8'h3C};
    vt[12] = '{1'b0, 8'h00, 1'b0, 3'b000, 8'h3C};

    v1[0] = '{1'b0, 1'b0, 1'b0};
    v1[1] = '{1'b1, 1'b1, 1'b0};
    v1[2] = '{1'b1, 1'b0, 1'b1};
    v1[3] = '{1'b1, 1'b1, 1'b1};
    v1[4] = '{1'b0, 1'b0, 1'b1};
    v1[5] = '{1'b0, 1'b1, 1'b0};

    // Check the reset state.
    do_reset();
    check("rst_stage", {29'h0, stage_o}, 32'h0);
    check("rst_ack_i", {31'h0, ack_i}, 32'h0);
    check("rst_req_o", {31'h0, req_o}, 32'h0);
    check("rst_data_o", {24'h0, data_o}, 32'h0);
    check("rst_err", {31'h0, err_o}, 32'h0);

    // Token, stall, release and drain.
    for (int i = 0; i < 13; i++) begin
      req_i  = vt[i].req;
      data_i = vt[i].d;
      ack_o  = vt[i].ack;
      step();
      check($sformatf("vec%0d_stage", i), {29'h0, stage_o}, {29'h0, vt[i].e_stage});
      check($sformatf("vec%0d_ack_i", i), {31'h0, ack_i}, {31'h0, vt[i].e_stage[0]});
      check($sformatf("vec%0d_req_o", i), {31'h0, req_o}, {31'h0, vt[i].e_stage[2]});
      check($sformatf("vec%0d_data_o", i), {24'h0, data_o}, {24'h0, vt[i].e_data});
      check($sformatf("vec%0d_err", i), {31'h0, err_o}, 32'h0);
    end
    check("sb_empty_after_table", sb.size(), 0);

    // Protocol error: req_i is raised while stage 1 still blocks ack_i.
    // It is then dropped before ack_i can rise.
    do_reset();
    req_i  = 1'b1;
    data_i = 8'h11;
    for (int i = 0; i < 3; i++) step();
    check("err_fill_stage", {29'h0, stage_o}, 32'h7);
    req_i = 1'b0;
    step();
    check("err_s110", {29'h0, stage_o}, 32'h6);
    req_i = 1'b1;
    step();
    check("err_s100", {29'h0, stage_o}, 32'h4);
    check("err_not_yet", {31'h0, err_o}, 32'h0);
    req_i = 1'b0;
    step();
    check("err_set", {31'h0, err_o}, 32'h1);
    ack_o = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("err_sticky%0d", i), {31'h0, err_o}, 32'h1);
    end
    check("err_drained", {29'h0, stage_o}, 32'h0);

    // Mid-operation reset while full and with err_o still set.
    ack_o  = 1'b0;
    req_i  = 1'b1;
    data_i = 8'h77;
    for (int i = 0; i < 3; i++) step();
    check("mid_full", {29'h0, stage_o}, 32'h7);
    #2;
    rst   = 1'b1;
    req_i = 1'b0;
    #1;
    check("mid_rst_stage", {29'h0, stage_o}, 32'h0);
    check("mid_rst_ack_i", {31'h0, ack_i}, 32'h0);
    check("mid_rst_req_o", {31'h0, req_o}, 32'h0);
    check("mid_rst_data_o", {24'h0, data_o}, 32'h0);
    check("mid_rst_err", {31'h0, err_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    prev_ack = 1'b0;
    prev_req = 1'b0;
    step();
    check("post_rst_idle", {29'h0, stage_o}, 32'h0);
    req_i  = 1'b1;
    data_i = 8'h5A;
    step();
    check("post_rst_e1", {29'h0, stage_o}, 32'h1);
    step();
    check("post_rst_e2", {29'h0, stage_o}, 32'h3);
    check("post_rst_e2_data", {24'h0, data_o}, 32'h0);
    step();
    check("post_rst_e3", {29'h0, stage_o}, 32'h7);
    check("post_rst_data", {24'h0, data_o}, 32'h5A);
    check("sb_empty_end", sb.size(), 0);

    // DEPTH=1: a single registered C(req_i, ~ack_o).
    do_reset();
    data1_i = 8'h96;
    for (int i = 0; i < 6; i++) begin
      req1_i = v1[i].req;
      ack1_o = v1[i].ack;
      step();
      check($sformatf("d1_vec%0d_req_o", i), {31'h0, req1_o}, {31'h0, v1[i].e_c});
      check($sformatf("d1_vec%0d_ack_i", i), {31'h0, ack1_i}, {31'h0, v1[i].e_c});
      if (i == 2) check("d1_data", {24'h0, data1_o}, 32'h96);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
